// File: rtl/com_pkg.sv
// -----------------------------------------------------------------------------
// com_pkg
// Shared definitions for the com4 command link:
//   - default bit period in clocks (12 MHz / 115200 baud)
//   - default inter-character gap in bit-times
//   - ASCII constants used to build a command frame
//   - frame length in characters
//   - FSM state types for the byte serialiser and the character sequencer
//   - nib2hex(): 4-bit value -> uppercase ASCII hex digit
// -----------------------------------------------------------------------------
package com_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 104;
    localparam int GAP_BITS_DEFAULT     = 2;

    localparam logic [7:0] CH_S  = 8'h53;   // 'S'
    localparam logic [7:0] CH_LF = 8'h0A;   // '\n'
    localparam logic [7:0] CH_0  = 8'h30;   // '0'

    localparam int FRAME_CHARS = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SEND,
        SEQ_GAP
    } seq_state_t;

    // 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37)
    function automatic logic [7:0] nib2hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return CH_0 + {4'd0, nib};
        end
        return 8'h37 + {4'd0, nib};
    endfunction

endpackage

// File: rtl/com_cmd_tx_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 UART byte serialiser, LSB first, each bit held CLKS_PER_BIT clocks.
// A byte is taken when in_valid && in_ready at a clock edge; the start bit
// is driven from that same edge. in_ready is also high on the last clock of
// the stop bit, so a byte offered then follows with no idle time between
// characters.
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous reset, active low
//   in_valid  in   byte offered
//   in_data   in   byte to send
//   in_ready  out  serialiser idle or finishing its stop bit
//   tx        out  UART line, idle high (registered)
// -----------------------------------------------------------------------------
module uart_tx_byte
    import com_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        shift_reg, shift_next;
    logic              tx_reg, tx_next;
    logic              bit_end;

    assign bit_end  = (baud_reg == BAUD_LAST);
    assign in_ready = (state_reg == TX_IDLE) || ((state_reg == TX_STOP) && bit_end);
    assign tx       = tx_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= TX_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;

        // Baud counter runs in every active state and wraps on each bit boundary;
        // it sits at 0 while idle.
        if (state_reg != TX_IDLE) begin
            baud_next = bit_end ? '0 : baud_reg + BAUD_W'(1);
        end

        if (in_valid && in_ready) begin
            state_next = TX_START;
            baud_next  = '0;
            bit_next   = '0;
            shift_next = in_data;
            tx_next    = 1'b0;
        end else begin
            case (state_reg)
                TX_START: begin
                    if (bit_end) begin
                        state_next = TX_DATA;
                        tx_next    = shift_reg[0];
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        if (bit_reg == 3'd7) begin
                            state_next = TX_STOP;
                            tx_next    = 1'b1;
                        end else begin
                            bit_next   = bit_reg + 3'd1;
                            shift_next = {1'b0, shift_reg[7:1]};
                            tx_next    = shift_reg[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        state_next = TX_IDLE;
                        tx_next    = 1'b1;
                    end
                end
                default: begin
                    state_next = TX_IDLE;
                    tx_next    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/com_cmd_tx.sv
// -----------------------------------------------------------------------------
// com_cmd_tx
// Host-side command initiator for the com4 link. Encodes one register write
// as the ASCII frame "S<ch><HI><LO>\n" and sends it through uart_tx_byte.
// Optional feature macro: COM_TX_GAP_EN -- when defined, TX idles for
// GAP_BITS bit-times after each of characters 0..3 (none after '\n').
// Ports:
//   CLK    in   system clock (12 MHz)
//   RST_N  in   synchronous reset, active low
//   SEND   in   request; accepted when SEND && READY at a CLK edge
//   ADDR   in   target channel 0..3 (sent as '0'..'3')
//   DATA   in   register value (sent as two uppercase hex digits)
//   READY  out  idle, able to accept a request
//   BUSY   out  ~READY
//   TX     out  UART line, idle high
// -----------------------------------------------------------------------------
module com_cmd_tx
    import com_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int GAP_BITS     = GAP_BITS_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SEND,
    input  logic [1:0] ADDR,
    input  logic [7:0] DATA,
    output logic       READY,
    output logic       BUSY,
    output logic       TX
);

`ifdef COM_TX_GAP_EN
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
`else
    // Gap disabled: GAP_BITS is accepted but contributes nothing, so the
    // gap branch below is constant-false and the counter is optimised away.
    localparam int GAP_CLKS = 0 * GAP_BITS;
`endif

    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [2:0]       LAST_CHAR = 3'(FRAME_CHARS - 1);

    seq_state_t       seq_reg, seq_next;
    logic [2:0]       char_idx_reg, char_idx_next;   // character currently on the line
    logic [1:0]       addr_reg, addr_next;
    logic [7:0]       data_reg, data_next;
    logic [GAP_W-1:0] gap_reg, gap_next;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;

    function automatic logic [7:0] frame_char(input logic [2:0] idx,
                                              input logic [1:0] a,
                                              input logic [7:0] d);
        case (idx)
            3'd0:    return CH_S;
            3'd1:    return CH_0 + {6'd0, a};
            3'd2:    return nib2hex(d[7:4]);
            3'd3:    return nib2hex(d[3:0]);
            default: return CH_LF;
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            seq_reg      <= SEQ_IDLE;
            char_idx_reg <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            gap_reg      <= '0;
        end else begin
            seq_reg      <= seq_next;
            char_idx_reg <= char_idx_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            gap_reg      <= gap_next;
        end
    end

    always_comb begin
        seq_next      = seq_reg;
        char_idx_next = char_idx_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        gap_next      = gap_reg;
        byte_valid    = 1'b0;
        byte_data     = CH_S;

        case (seq_reg)
            SEQ_IDLE: begin
                // 'S' goes straight to the serialiser so the start bit
                // leaves on the accepting edge.
                if (SEND) begin
                    byte_valid    = 1'b1;
                    byte_data     = CH_S;
                    addr_next     = ADDR;
                    data_next     = DATA;
                    char_idx_next = '0;
                    seq_next      = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                // While a character is in flight, byte_ready marks the last
                // clock of its stop bit.
                if (byte_ready) begin
                    if (char_idx_reg == LAST_CHAR) begin
                        seq_next = SEQ_IDLE;
                    end else begin
                        char_idx_next = char_idx_reg + 3'd1;
                        if (GAP_CLKS > 0) begin
                            seq_next = SEQ_GAP;
                            gap_next = '0;
                        end else begin
                            byte_valid = 1'b1;
                            byte_data  = frame_char(char_idx_reg + 3'd1, addr_reg, data_reg);
                        end
                    end
                end
            end
            SEQ_GAP: begin
                if ((gap_reg == GAP_LAST) && byte_ready) begin
                    byte_valid = 1'b1;
                    byte_data  = frame_char(char_idx_reg, addr_reg, data_reg);
                    seq_next   = SEQ_SEND;
                end else begin
                    gap_next = gap_reg + GAP_W'(1);
                end
            end
            default: begin
                seq_next = SEQ_IDLE;
            end
        endcase
    end

    assign READY = (seq_reg == SEQ_IDLE);
    assign BUSY  = ~READY;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk      (CLK),
        .rst_n    (RST_N),
        .in_valid (byte_valid),
        .in_data  (byte_data),
        .in_ready (byte_ready),
        .tx       (TX)
    );

endmodule
